// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared flit format, crossbar port indices and XY route function.
// Revision : 1.0
// ============================================================================
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_L    = 0;
    localparam int PORT_N    = 1;
    localparam int PORT_E    = 2;
    localparam int PORT_S    = 3;
    localparam int PORT_W    = 4;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e  ftype;
        logic [2:0]  dest_x;
        logic [2:0]  dest_y;
        logic [7:0]  payload;
    } flit_t;

    // Dimension-ordered routing: resolve X completely before Y.
    function automatic logic [NUM_PORTS-1:0] xy_route(
        input logic [2:0] dest_x,
        input logic [2:0] dest_y,
        input logic [2:0] x,
        input logic [2:0] y
    );
        logic [NUM_PORTS-1:0] w_route;
        w_route = '0;
        if (dest_x > x)
            w_route[PORT_E] = 1'b1;
        else if (dest_x < x)
            w_route[PORT_W] = 1'b1;
        else if (dest_y > y)
            w_route[PORT_N] = 1'b1;
        else if (dest_y < y)
            w_route[PORT_S] = 1'b1;
        else
            w_route[PORT_L] = 1'b1;
        return w_route;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_flit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : noc_flit_fifo
// Brief    : DEPTH-entry circular flit buffer with occupancy count and overflow.
// Revision : 1.0
// ============================================================================
module noc_flit_fifo #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Fullness is judged before any same-cycle pop, so a push into a full
    // buffer is dropped even when a slot frees up at the same edge.
    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign overflow  = push && full;
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// Module   : noc_input_port
// Brief    : Router input port: flit buffer, XY route request, packet forward,
//            credit return and sticky protocol error flag.
// Revision : 1.0
// ============================================================================
module noc_input_port
    import noc_pkg::*;
#(
    parameter int         DEPTH   = 5,
    parameter logic [2:0] X_COORD = 3'd0,
    parameter logic [2:0] Y_COORD = 3'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          data_i,
    input  logic                 valid_i,
    output logic                 credit_o,
    output logic [NUM_PORTS-1:0] req_o,
    input  logic                 grant_i,
    input  logic                 out_ready_i,
    output logic [15:0]          data_o,
    output logic                 valid_o,
    output logic                 error_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FWD  = 2'd2
    } state_e;

    state_e                 r_state;
    logic                   r_first;
    logic                   r_credit;
    logic [NUM_PORTS-1:0]   r_req;
    logic [15:0]            r_data;
    logic                   r_valid;
    logic                   r_error;

    logic [15:0]            w_fifo_dout;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH+1)-1:0] w_count;
    logic                   w_overflow;
    logic                   w_pop;
    logic                   w_is_head;
    logic                   w_is_tail;
    flit_t                  w_head_flit;
    logic                   w_unused;

    noc_flit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (valid_i),
        .pop      (w_pop),
        .din      (data_i),
        .dout     (w_fifo_dout),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count),
        .overflow (w_overflow)
    );

    assign w_unused    = &{1'b0, w_full, w_count};
    assign w_head_flit = w_fifo_dout;
    assign w_is_head   = (w_head_flit.ftype == FLIT_HEAD) || (w_head_flit.ftype == FLIT_SINGLE);
    assign w_is_tail   = (w_head_flit.ftype == FLIT_TAIL) || (w_head_flit.ftype == FLIT_SINGLE);

    // Orphan body/tail flits in IDLE are drained so their credit still returns.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = !w_empty && !w_is_head;
            ST_FWD:  w_pop = !w_empty && out_ready_i;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_first  <= 1'b0;
            r_credit <= 1'b0;
            r_req    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_credit <= w_pop;
            r_valid  <= 1'b0;
            if (w_overflow)
                r_error <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_is_head) begin
                            r_req   <= xy_route(w_head_flit.dest_x, w_head_flit.dest_y,
                                                X_COORD, Y_COORD);
                            r_state <= ST_REQ;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (grant_i) begin
                        r_state <= ST_FWD;
                        r_first <= 1'b1;
                    end
                end
                ST_FWD: begin
                    if (w_pop) begin
                        r_data  <= w_head_flit;
                        r_valid <= 1'b1;
                        r_first <= 1'b0;
                        if (w_is_head && !r_first)
                            r_error <= 1'b1;
                        if (w_is_tail) begin
                            r_req   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign credit_o = r_credit;
    assign req_o    = r_req;
    assign data_o   = r_data;
    assign valid_o  = r_valid;
    assign error_o  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_noc_input_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_input_port
// Brief    : Directed self-checking bench with a flit scoreboard, X=1 Y=1.
// Revision : 1.0
// ============================================================================
module tb_noc_input_port;

    logic        clk;
    logic        rst;
    logic [15:0] data_i;
    logic        valid_i;
    logic        credit_o;
    logic [4:0]  req_o;
    logic        grant_i;
    logic        out_ready_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        error_o;

    int          total = 0;
    int          bad = 0;
    int          n_valid = 0;
    int          n_credit = 0;
    logic [15:0] sb [$];
    logic [15:0] exp_flit;

    noc_input_port #(
        .DEPTH   (5),
        .X_COORD (3'd1),
        .Y_COORD (3'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .credit_o    (credit_o),
        .req_o       (req_o),
        .grant_i     (grant_i),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .error_o     (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] f, input bit fwd);
        data_i  = f;
        valid_i = 1'b1;
        if (fwd)
            sb.push_back(f);
        tick(1);
        valid_i = 1'b0;
        data_i  = 16'h0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++)
            tick(1);
        check(tag, sb.size(), 0);
        tick(3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_credit"}, credit_o, 0);
        check({tag, "_req"},    req_o,    0);
        check({tag, "_valid"},  valid_o,  0);
        check({tag, "_data"},   data_o,   0);
        check({tag, "_error"},  error_o,  0);
    endtask

    // Output monitor: every forwarded flit must match the scoreboard head.
    always @(negedge clk) begin
        if (credit_o === 1'b1)
            n_credit++;
        if (valid_o === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_flit observed=%0h expected=none", data_o);
            end else begin
                exp_flit = sb.pop_front();
                check("flit_data", data_o, exp_flit);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; data_i = 16'h0; valid_i = 1'b0;
        grant_i = 1'b0; out_ready_i = 1'b0;
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Single-flit packet routed East.
        grant_i = 1'b1; out_ready_i = 1'b1;
        n_valid = 0; n_credit = 0;
        push(16'hD9A5, 1'b1);
        tick(1);
        check("single_req_east", req_o, 5'b00100);
        drain("single_drain", 20);
        check("single_nvalid", n_valid, 1);
        check("single_ncredit", n_credit, 1);
        check("single_req_clear", req_o, 0);
        check("single_data_held", data_o, 16'hD9A5);
        check("single_error", error_o, 0);

        // Four-flit packet routed South with a delayed grant.
        grant_i = 1'b0;
        n_valid = 0; n_credit = 0;
        push(16'h4811, 1'b1);
        push(16'h1234, 1'b1);
        push(16'h0567, 1'b1);
        push(16'h8ABC, 1'b1);
        check("pkt_req_south", req_o, 5'b01000);
        tick(3);
        check("pkt_req_held", req_o, 5'b01000);
        check("pkt_no_valid_before_grant", n_valid, 0);
        grant_i = 1'b1;
        drain("pkt_drain", 30);
        check("pkt_nvalid", n_valid, 4);
        check("pkt_ncredit", n_credit, 4);
        check("pkt_req_clear", req_o, 0);
        check("pkt_error", error_o, 0);

        // Backpressure: fill the buffer, overflow it, then release.
        out_ready_i = 1'b0;
        n_valid = 0; n_credit = 0;
        push(16'h4133, 1'b1);
        push(16'h0011, 1'b1);
        push(16'h0022, 1'b1);
        push(16'h0033, 1'b1);
        push(16'h8044, 1'b1);
        check("bp_error_before", error_o, 0);
        push(16'h3FFF, 1'b0);
        check("bp_overflow_error", error_o, 1);
        check("bp_no_credit", n_credit, 0);
        check("bp_no_valid", n_valid, 0);
        check("bp_req_west", req_o, 5'b10000);
        out_ready_i = 1'b1;
        drain("bp_drain", 30);
        check("bp_nvalid", n_valid, 5);
        check("bp_ncredit", n_credit, 5);
        check("bp_req_clear", req_o, 0);
        rst = 1'b1;
        tick(1);
        check("bp_reset_error", error_o, 0);
        rst = 1'b0;

        // Orphan body flit arriving at an idle port.
        n_valid = 0; n_credit = 0;
        push(16'h0123, 1'b0);
        tick(1);
        check("orphan_req", req_o, 0);
        tick(3);
        check("orphan_ncredit", n_credit, 1);
        check("orphan_error", error_o, 1);
        check("orphan_nvalid", n_valid, 0);
        check("orphan_req_after", req_o, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // Local delivery, then a North-bound single flit.
        n_valid = 0; n_credit = 0;
        push(16'hC95A, 1'b1);
        tick(1);
        check("local_req", req_o, 5'b00001);
        drain("local_drain", 20);
        push(16'hCB77, 1'b1);
        tick(1);
        check("north_req", req_o, 5'b00010);
        drain("north_drain", 20);
        check("local_north_nvalid", n_valid, 2);
        check("local_north_error", error_o, 0);

        // Reset in the middle of a packet after two flits have left.
        out_ready_i = 1'b0;
        n_valid = 0; n_credit = 0;
        push(16'h4A44, 1'b1);
        push(16'h0001, 1'b1);
        push(16'h0002, 1'b1);
        push(16'h8003, 1'b1);
        out_ready_i = 1'b1;
        tick(2);
        check("mid_valid_second", valid_o, 1);
        check("mid_data_second", data_o, 16'h0001);
        rst = 1'b1;
        tick(1);
        check_all_zero("mid_reset");
        sb.delete();
        rst = 1'b0;
        tick(3);
        check("mid_nvalid", n_valid, 2);
        check("mid_ncredit", n_credit, 2);
        push(16'h5166, 1'b1);
        push(16'h8004, 1'b1);
        check("mid_new_req_east", req_o, 5'b00100);
        drain("mid_new_drain", 20);
        check("mid_new_nvalid", n_valid, 4);
        check("mid_new_ncredit", n_credit, 4);
        check("mid_new_error", error_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
